// File: rtl/uarch_pkg.sv
// uarch_pkg: writeback packet type, CDB sizing constants and requester indices
package uarch_pkg;

    localparam int NUM_REQ = 4;
    localparam int NUM_CDB = 2;
    localparam int TAG_W   = 6;
    localparam int DATA_W  = 32;

    localparam logic [1:0] REQ_ALU0   = 2'd0;
    localparam logic [1:0] REQ_ALU1   = 2'd1;
    localparam logic [1:0] REQ_MDU    = 2'd2;
    localparam logic [1:0] REQ_DCACHE = 2'd3;

    typedef struct packed {
        logic              val;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              exception;
    } writeback_packet_t;

    // One-hot to index; an all-zero vector maps to 0.
    function automatic logic [1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (oh[i]) oh2idx = 2'(i);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational round-robin picker returning the first two requesters from ptr
import uarch_pkg::*;

module rr_pick2 (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_REQ-1:0] gnt0_o,
    output logic [NUM_REQ-1:0] gnt1_o,
    output logic               vld0_o,
    output logic               vld1_o,
    output logic [1:0]         last_o
);

    // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); first hit goes to slot 0, second to slot 1.
    always_comb begin
        logic [1:0] idx;
        idx    = ptr_i;
        gnt0_o = '0;
        gnt1_o = '0;
        vld0_o = 1'b0;
        vld1_o = 1'b0;
        last_o = ptr_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr_i + 2'(i);
            if (req_i[idx] && !vld0_o) begin
                gnt0_o[idx] = 1'b1;
                vld0_o      = 1'b1;
                last_o      = idx;
            end else if (req_i[idx] && !vld1_o) begin
                gnt1_o[idx] = 1'b1;
                vld1_o      = 1'b1;
                last_o      = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin writeback arbiter of four FU results onto two registered CDB ports.
// Define CDB_DCACHE_PRIO_EN to give a valid dcache result fixed priority on port0.
import uarch_pkg::*;

module cdb_arbiter #(
    parameter logic [1:0] PTR_RESET = 2'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  writeback_packet_t alu_result0,
    input  writeback_packet_t alu_result1,
    input  writeback_packet_t mdu_result,
    input  writeback_packet_t dcache_result,
    output logic              alu_cdb_gnt0,
    output logic              alu_cdb_gnt1,
    output logic              mdu_cdb_gnt,
    output logic              dcache_cdb_gnt,
    output writeback_packet_t cdb_port0,
    output writeback_packet_t cdb_port1
);

    writeback_packet_t res [NUM_REQ];
    writeback_packet_t port0_d, port0_q, port1_d, port1_q;
    logic [1:0]         ptr_d, ptr_q, pick_last, last;
    logic [NUM_REQ-1:0] req, pick_req, pg0, pg1, g0, g1;
    logic               pv0, pv1, v0, v1, en;

    assign res[REQ_ALU0]   = alu_result0;
    assign res[REQ_ALU1]   = alu_result1;
    assign res[REQ_MDU]    = mdu_result;
    assign res[REQ_DCACHE] = dcache_result;
    assign req = {dcache_result.val, mdu_result.val, alu_result1.val, alu_result0.val};

    // Grants are killed while in reset and on flush.
    assign en = rst & ~flush;

`ifdef CDB_DCACHE_PRIO_EN
    // dcache owns port0 when valid; round-robin only ever covers the other three.
    assign pick_req = {1'b0, req[2:0]};
    assign g0   = (req[REQ_DCACHE] ? 4'b1000 : pg0) & {NUM_REQ{en}};
    assign g1   = (req[REQ_DCACHE] ? pg0 : pg1) & {NUM_REQ{en}};
    assign v0   = (req[REQ_DCACHE] | pv0) & en;
    assign v1   = (req[REQ_DCACHE] ? pv0 : pv1) & en;
    assign last = req[REQ_DCACHE] ? oh2idx(pg0) : pick_last;
`else
    assign pick_req = req;
    assign g0   = pg0 & {NUM_REQ{en}};
    assign g1   = pg1 & {NUM_REQ{en}};
    assign v0   = pv0 & en;
    assign v1   = pv1 & en;
    assign last = pick_last;
`endif

    rr_pick2 u_pick (
        .req_i  (pick_req),
        .ptr_i  (ptr_q),
        .gnt0_o (pg0),
        .gnt1_o (pg1),
        .vld0_o (pv0),
        .vld1_o (pv1),
        .last_o (pick_last)
    );

    assign {dcache_cdb_gnt, mdu_cdb_gnt, alu_cdb_gnt1, alu_cdb_gnt0} = g0 | g1;
    assign cdb_port0 = port0_q;
    assign cdb_port1 = port1_q;

    // Route the granted packets to the port inputs and advance the pointer past the last round-robin grant.
    always_comb begin
        port0_d = '0;
        port1_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g0[i]) port0_d = res[i];
            if (g1[i]) port1_d = res[i];
        end
        port0_d.val = v0;
        port1_d.val = v1;
        ptr_d = flush ? PTR_RESET : (pv0 ? last + 2'd1 : ptr_q);
    end

    // Registered CDB ports and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port0_q <= '0;
            port1_q <= '0;
            ptr_q   <= PTR_RESET;
        end else begin
            port0_q <= port0_d;
            port1_q <= port1_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter
import uarch_pkg::*;

module tb_cdb_arbiter;

    logic clk = 1'b0;
    logic rst, flush;
    writeback_packet_t a0, a1, md, dc, cdb_port0, cdb_port1;
    logic alu_cdb_gnt0, alu_cdb_gnt1, mdu_cdb_gnt, dcache_cdb_gnt;
    logic [3:0] gnt;
    int vectors = 0;
    int errs = 0;
    writeback_packet_t q0[$], q1[$];

    localparam writeback_packet_t NV = '0;
    localparam writeback_packet_t PA0 = '{1'b1, 6'h01, 32'h1111_0000, 1'b0};
    localparam writeback_packet_t PA1 = '{1'b1, 6'h02, 32'h2222_0001, 1'b1};
    localparam writeback_packet_t PMD = '{1'b1, 6'h03, 32'h3333_0002, 1'b0};
    localparam writeback_packet_t PDC = '{1'b1, 6'h04, 32'h4444_0003, 1'b1};
    localparam writeback_packet_t PMB = '{1'b1, 6'h2A, 32'hDEAD_BEEF, 1'b0};

    cdb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .alu_result0    (a0),
        .alu_result1    (a1),
        .mdu_result     (md),
        .dcache_result  (dc),
        .alu_cdb_gnt0   (alu_cdb_gnt0),
        .alu_cdb_gnt1   (alu_cdb_gnt1),
        .mdu_cdb_gnt    (mdu_cdb_gnt),
        .dcache_cdb_gnt (dcache_cdb_gnt),
        .cdb_port0      (cdb_port0),
        .cdb_port1      (cdb_port1)
    );

    always #5 clk = ~clk;

    assign gnt = {dcache_cdb_gnt, mdu_cdb_gnt, alu_cdb_gnt1, alu_cdb_gnt0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // An invalid expected packet leaves the other fields unchecked.
    task automatic chkp(input string tag, input writeback_packet_t obs, input writeback_packet_t exp);
        if (exp.val) chk(tag, 64'(obs), 64'(exp));
        else         chk(tag, 64'(obs.val), 64'(1'b0));
    endtask

    task automatic drive(input writeback_packet_t p0, p1, p2, p3, input logic f);
        a0 = p0; a1 = p1; md = p2; dc = p3; flush = f;
    endtask

    task automatic step(input string tag, input logic [3:0] eg,
                        input writeback_packet_t e0, e1, input logic [1:0] ep);
        writeback_packet_t x0, x1;
        @(negedge clk);
        chk({tag, ".gnt"}, 64'(gnt), 64'(eg));
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1;
        x0 = q0.pop_front();
        x1 = q1.pop_front();
        chkp({tag, ".p0"}, cdb_port0, x0);
        chkp({tag, ".p1"}, cdb_port1, x1);
        chk({tag, ".ptr"}, 64'(dut.ptr_q), 64'(ep));
    endtask

    initial begin
        rst = 1'b1;
        drive(NV, NV, NV, NV, 1'b0);
        #2 rst = 1'b0;
        drive(PA0, NV, NV, NV, 1'b0);
        @(posedge clk);
        #1;
        chk("rst.p0", 64'(cdb_port0), 64'(0));
        chk("rst.p1", 64'(cdb_port1), 64'(0));
        chk("rst.gnt", 64'(gnt), 64'(0));
        chk("rst.ptr", 64'(dut.ptr_q), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        drive(NV, NV, NV, NV, 1'b0);
        step("idle", 4'b0000, NV, NV, 2'd0);
`ifdef CDB_DCACHE_PRIO_EN
        drive(PA0, PA1, NV, PDC, 1'b0);
        step("prio3", 4'b1011, PDC, PA0, 2'd1);
        drive(NV, NV, NV, PDC, 1'b0);
        step("prio_dc_only", 4'b1000, PDC, NV, 2'd1);
`else
        drive(PA0, PA1, PMD, PDC, 1'b0);
        step("all4a", 4'b0011, PA0, PA1, 2'd2);
        step("all4b", 4'b1100, PMD, PDC, 2'd0);
        drive(NV, NV, PMD, NV, 1'b0);
        step("mdu_p0", 4'b0100, PMD, NV, 2'd3);
        drive(NV, NV, PMB, NV, 1'b0);
        step("mdu_p3", 4'b0100, PMB, NV, 2'd3);
        drive(PA0, NV, NV, PDC, 1'b0);
        step("wrap", 4'b1001, PDC, PA0, 2'd1);
        drive(PA0, NV, NV, PDC, 1'b1);
        #1 chk("flush.hold", 64'(cdb_port0), 64'(PDC));
        step("flush", 4'b0000, NV, NV, 2'd0);
        drive(NV, PA1, PMD, NV, 1'b0);
        step("a1_mdu", 4'b0110, PA1, PMD, 2'd3);
        drive(PA0, PA1, NV, NV, 1'b0);
        step("p3_a0a1", 4'b0011, PA0, PA1, 2'd2);
        drive(PA0, PA1, PMD, PDC, 1'b0);
        #3 rst = 1'b0;
        #1;
        chk("arst.p0", 64'(cdb_port0), 64'(0));
        chk("arst.p1", 64'(cdb_port1), 64'(0));
        chk("arst.gnt", 64'(gnt), 64'(0));
        chk("arst.ptr", 64'(dut.ptr_q), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        drive(NV, PA1, NV, NV, 1'b0);
        step("post_rst", 4'b0010, PA1, NV, 2'd2);
`endif
        drive(NV, NV, NV, NV, 1'b0);
        step("drain", 4'b0000, NV, NV, dut.ptr_q);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Writeback stage directly downstream of execute.
- Arbitrates the four functional-unit results (alu0, alu1, mdu, dcache) onto the two common data bus ports.
- Returns per-FU grants to execute and drives registered cdb_port0/cdb_port1, which feed the forwarding network, reservation stations and ROB.
- Fair round-robin across requesters, up to two grants per cycle.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4 for the named ports, used for internal vector sizing.
- NUM_CDB, 2, number of CDB ports; fixed at 2.
- PTR_RESET, 0, round-robin pointer value after reset/flush (0..NUM_REQ-1).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush (mispredict/exception)
- alu_result0  in  writeback_packet_t  ALU0 result; req index 0
- alu_result1  in  writeback_packet_t  ALU1 result; req index 1
- mdu_result  in  writeback_packet_t  MDU result; req index 2
- dcache_result  in  writeback_packet_t  load result; req index 3
- alu_cdb_gnt0  out  1  grant to ALU0
- alu_cdb_gnt1  out  1  grant to ALU1
- mdu_cdb_gnt  out  1  grant to MDU
- dcache_cdb_gnt  out  1  grant to dcache path
- cdb_port0  out  writeback_packet_t  CDB broadcast port 0
- cdb_port1  out  writeback_packet_t  CDB broadcast port 1

Behaviour:
- Request: input packet .val=1. The FU holds the packet stable until it samples its grant high at a rising edge. Grants are combinational from the current .val and the pointer; no grant ever goes to a request with .val=0.
- Selection: scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - First valid requester is granted and routed to port0.
  - Second valid requester is granted and routed to port1.
  - All others are denied; at most 2 grants per cycle.
- Latency: a packet granted in cycle N appears on cdb_portX in cycle N+1 with .val=1. Ports are registered; a port with no winner registers .val=0, and its other fields are don't-care but still registered.
- Pointer:
  - On any grant, ptr <= (index of last grant this cycle + 1) mod 4.
  - With no grant, ptr is unchanged.
  - Wrap 3->0 is natural modulo.
  - Guarantee: a continuously valid requester is granted within 2 cycles.
- Single valid requester: always port0; port1 .val=0.
- Flush, cycle N:
  - All grants forced to 0 in cycle N.
  - Both ports register .val=0, so ports are invalid in N+1.
  - ptr <= PTR_RESET.
  - Packets already on the ports in cycle N are still broadcast; flush does not retract the current outputs.
- Reset (rst=0, asynchronous, any time including mid-stream):
  - cdb_port0/cdb_port1 all fields 0 (.val=0).
  - ptr = PTR_RESET.
  - Grants evaluate to 0 while in reset.
- Simultaneous flush and requests: flush wins; no grants.
- No combinational path from grants back into selection other than through ptr.

Optional Feature:
- Macro: CDB_DCACHE_PRIO_EN.
- Defined:
  - A valid dcache_result always takes port0 regardless of ptr.
  - The remaining port goes to the first valid of indices 0..2, scanned round-robin from ptr (index 3 skipped).
  - ptr update ignores a dcache grant; if only dcache is granted, ptr is unchanged.
  - Frees the load path from backpressure.
- Undefined: dcache is an ordinary round-robin requester, as above.

Decomposition:
- uarch_pkg: writeback_packet_t (fields val, dest tag, data, exception), the NUM_REQ/NUM_CDB constants, and the requester-index localparams.
- One sub-module: rr_pick2. Combinational; takes a 4-bit request vector and a 2-bit ptr, returns two one-hot grants, their valid flags and the last-granted index.
- cdb_arbiter holds the ptr register, the output registers, the muxing and the flush/reset handling.

Test Plan:
- Reset, then no requests -> all grants 0, both ports .val=0, ptr=0.
- ptr=0, all four valid -> cycle N: gnt alu0, alu1. N+1: port0=alu0, port1=alu1, ptr=2. Held requests in N+1 -> gnt mdu, dcache; N+2: port0=mdu, port1=dcache, ptr=0.
- Only mdu valid (data 0xDEADBEEF), ptr=3 -> mdu_cdb_gnt=1, other grants 0. Next cycle port0.data=0xDEADBEEF, port1.val=0, ptr=3.
- Flush asserted with alu0 and dcache valid -> no grants. Next cycle both ports .val=0, ptr=PTR_RESET.
- rst dropped mid-burst, between clock edges -> ports clear immediately, without waiting for an edge. After rst release with alu1 valid -> alu1 granted on port0.
- CDB_DCACHE_PRIO_EN, ptr=0, alu0, alu1 and dcache valid -> port0=dcache, port1=alu0, alu1 denied, ptr=1.
